l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/l2_arbiter.sv | 173 +++++++++++++++++
 tb/tb_l2_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the instruction-side and data-side
// L1 miss paths. One L2 transaction is in flight at a time. When both sides
// request together, a round-robin bit picks the side served less recently.
// Each grant captures the request into local registers so the requester may
// change its inputs while the L2 transaction is in progress.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  // last_served encoding: 0 = instruction side, 1 = data side
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t              state;
  state_t              next_state;
  logic                last_served;

  logic [ADDR_W-1:0]   lat_address;
  logic                lat_write;
  logic [LINE_W-1:0]   lat_wdata;

  logic                i_req;
  logic                d_req;
  logic                grant_i;
  logic                grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Round-robin choice among pending requesters; only meaningful in IDLE
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_req && d_req) begin
        grant_d = (last_served == SIDE_I);
        grant_i = (last_served == SIDE_D);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: every transaction returns to IDLE, which guarantees an idle gap
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          next_state = SERVE_D;
        end else if (grant_i) begin
          next_state = SERVE_I;
        end else begin
          next_state = IDLE;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Round-robin history, updated when a transaction completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_served <= SIDE_I;
    end else if (state == SERVE_I && l2_resp) begin
      last_served <= SIDE_I;
    end else if (state == SERVE_D && l2_resp) begin
      last_served <= SIDE_D;
    end
  end

  // Capture the granted request; a data-side write takes priority over a read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_address <= '0;
      lat_write   <= 1'b0;
      lat_wdata   <= '0;
    end else if (grant_d) begin
      lat_address <= d_address;
      lat_write   <= d_write;
      lat_wdata   <= d_wdata;
    end else if (grant_i) begin
      lat_address <= i_address;
      lat_write   <= 1'b0;
      lat_wdata   <= '0;
    end
  end

  // Output decode: L2 command from captured registers, responses gated by the serving state
  always_comb begin
    l2_address = '0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      SERVE_I: begin
        l2_address = lat_address;
        l2_wdata   = lat_wdata;
        l2_read    = 1'b1;
        i_resp     = l2_resp;
      end
      SERVE_D: begin
        l2_address = lat_address;
        l2_wdata   = lat_wdata;
        l2_read    = ~lat_write;
        l2_write   = lat_write;
        d_resp     = l2_resp;
      end
      default: begin
        l2_address = '0;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_wdata   = '0;
      end
    endcase
  end

  // Returned line goes to both requesters; only the resp strobe says whose it is
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed vectors for l2_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_l2_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] l2_address;
  logic              l2_read;
  logic              l2_write;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  int check_count;
  int fail_count;

  logic [LINE_W-1:0] line_a5;
  logic [LINE_W-1:0] line_dead;
  logic [LINE_W-1:0] line_11;
  logic [LINE_W-1:0] line_3c;

  l2_arbiter #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_address  (i_address),
    .i_read     (i_read),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_address  (d_address),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .l2_address (l2_address),
    .l2_read    (l2_read),
    .l2_write   (l2_write),
    .l2_wdata   (l2_wdata),
    .l2_rdata   (l2_rdata),
    .l2_resp    (l2_resp)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                             input logic [LINE_W-1:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive every requester and L2-side input in one call
  task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia,
                               input logic dr, input logic dw,
                               input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] dwd,
                               input logic rsp, input logic [LINE_W-1:0] rd);
    i_read    = ir;
    i_address = ia;
    d_read    = dr;
    d_write   = dw;
    d_address = da;
    d_wdata   = dwd;
    l2_resp   = rsp;
    l2_rdata  = rd;
  endtask

  // Advance to just after the next rising edge, where inputs are changed
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point of the current cycle
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    check_count = 0;
    fail_count  = 0;
    line_a5   = {32{8'hA5}};
    line_dead = {8{32'hDEADBEEF}};
    line_11   = {32{8'h11}};
    line_3c   = {32{8'h3C}};

    // Reset state: commands low, resp gated even with l2_resp high, rdata follows L2
    rst = 1'b0;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h80, line_dead, 1'b1, line_11);
    #3;
    checkOutput("rst_l2_read",  LINE_W'(l2_read),    '0);
    checkOutput("rst_l2_write", LINE_W'(l2_write),   '0);
    checkOutput("rst_l2_addr",  LINE_W'(l2_address), '0);
    checkOutput("rst_l2_wdata", l2_wdata,            '0);
    checkOutput("rst_i_resp",   LINE_W'(i_resp),     '0);
    checkOutput("rst_d_resp",   LINE_W'(d_resp),     '0);
    checkOutput("rst_i_rdata",  i_rdata,             line_11);
    checkOutput("rst_d_rdata",  d_rdata,             line_11);
    doReset();

    // Single instruction read at 0x40, L2 answers in cycle 5
    step();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    sample();
    checkOutput("t1_idle_read", LINE_W'(l2_read), '0);
    step();
    i_read = 1'b0;
    sample();
    checkOutput("t1_c1_read", LINE_W'(l2_read),    1);
    checkOutput("t1_c1_addr", LINE_W'(l2_address), 32'h40);
    checkOutput("t1_c1_wr",   LINE_W'(l2_write),   '0);
    for (int c = 2; c <= 4; c++) begin
      step();
      sample();
      checkOutput($sformatf("t1_c%0d_read", c), LINE_W'(l2_read), 1);
      checkOutput($sformatf("t1_c%0d_iresp", c), LINE_W'(i_resp), '0);
    end
    step();
    l2_resp  = 1'b1;
    l2_rdata = line_a5;
    sample();
    checkOutput("t1_c5_read",   LINE_W'(l2_read), 1);
    checkOutput("t1_c5_iresp",  LINE_W'(i_resp),  1);
    checkOutput("t1_c5_dresp",  LINE_W'(d_resp),  '0);
    checkOutput("t1_c5_irdata", i_rdata,          line_a5);
    step();
    l2_resp = 1'b0;
    sample();
    checkOutput("t1_end_read",  LINE_W'(l2_read), '0);
    checkOutput("t1_end_iresp", LINE_W'(i_resp),  '0);

    // L2 response while idle is ignored
    step();
    l2_resp = 1'b1;
    sample();
    checkOutput("idle_resp_i", LINE_W'(i_resp), '0);
    checkOutput("idle_resp_d", LINE_W'(d_resp), '0);
    step();
    l2_resp = 1'b0;
    sample();
    checkOutput("idle_resp_state", LINE_W'(l2_read), '0);

    // Both pending after reset: D first, idle gap, then I
    doReset();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0, 1'b0, '0);
    sample();
    checkOutput("t2_idle_read", LINE_W'(l2_read), '0);
    step();
    d_read = 1'b0;
    sample();
    checkOutput("t2_d_addr",  LINE_W'(l2_address), 32'h200);
    checkOutput("t2_d_read",  LINE_W'(l2_read),    1);
    checkOutput("t2_d_write", LINE_W'(l2_write),   '0);
    step();
    step();
    l2_resp  = 1'b1;
    l2_rdata = line_3c;
    sample();
    checkOutput("t2_d_resp",   LINE_W'(d_resp), 1);
    checkOutput("t2_d_iresp",  LINE_W'(i_resp), '0);
    checkOutput("t2_d_rdata",  d_rdata,         line_3c);
    step();
    l2_resp = 1'b0;
    sample();
    checkOutput("t2_gap_read", LINE_W'(l2_read),    '0);
    checkOutput("t2_gap_addr", LINE_W'(l2_address), '0);
    step();
    i_read = 1'b0;
    sample();
    checkOutput("t2_i_addr", LINE_W'(l2_address), 32'h100);
    checkOutput("t2_i_read", LINE_W'(l2_read),    1);
    step();
    l2_resp = 1'b1;
    sample();
    checkOutput("t2_i_resp",  LINE_W'(i_resp), 1);
    checkOutput("t2_i_dresp", LINE_W'(d_resp), '0);
    step();
    l2_resp = 1'b0;

    // Write with read also set: write wins; inputs changed mid-transaction are ignored
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h300, line_dead, 1'b0, '0);
    sample();
    checkOutput("t3_idle_write", LINE_W'(l2_write), '0);
    step();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h999, '0, 1'b0, '0);
    sample();
    checkOutput("t3_write", LINE_W'(l2_write),   1);
    checkOutput("t3_read",  LINE_W'(l2_read),    '0);
    checkOutput("t3_addr",  LINE_W'(l2_address), 32'h300);
    checkOutput("t3_wdata", l2_wdata,            line_dead);
    step();
    sample();
    checkOutput("t3_hold_addr",  LINE_W'(l2_address), 32'h300);
    checkOutput("t3_hold_write", LINE_W'(l2_write),   1);
    checkOutput("t3_hold_wdata", l2_wdata,            line_dead);
    step();
    l2_resp = 1'b1;
    sample();
    checkOutput("t3_dresp", LINE_W'(d_resp), 1);
    checkOutput("t3_iresp", LINE_W'(i_resp), '0);
    step();
    l2_resp = 1'b0;
    sample();
    checkOutput("t3_end_write", LINE_W'(l2_write), '0);

    // Reset in the middle of an instruction read abandons it
    step();
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step();
    i_read = 1'b0;
    sample();
    checkOutput("t4_pre_read", LINE_W'(l2_read), 1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t4_async_read", LINE_W'(l2_read),    '0);
    checkOutput("t4_async_addr", LINE_W'(l2_address), '0);
    step();
    rst     = 1'b1;
    l2_resp = 1'b1;
    sample();
    checkOutput("t4_post_iresp", LINE_W'(i_resp),  '0);
    checkOutput("t4_post_read",  LINE_W'(l2_read), '0);
    step();
    l2_resp = 1'b0;
    sample();
    checkOutput("t4_end_read", LINE_W'(l2_read), '0);

    // Continuous contention: six grants alternate D,I,D,I,D,I with an idle cycle between
    doReset();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0, 1'b0, '0);
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      step();
      sample();
      checkOutput($sformatf("t5_%0d_addr", k), LINE_W'(l2_address),
                  exp_d ? LINE_W'(32'h200) : LINE_W'(32'h100));
      checkOutput($sformatf("t5_%0d_read", k), LINE_W'(l2_read), 1);
      step();
      l2_resp = 1'b1;
      sample();
      checkOutput($sformatf("t5_%0d_dresp", k), LINE_W'(d_resp), LINE_W'(exp_d));
      checkOutput($sformatf("t5_%0d_iresp", k), LINE_W'(i_resp), LINE_W'(!exp_d));
      step();
      l2_resp = 1'b0;
      sample();
      checkOutput($sformatf("t5_%0d_gap", k), LINE_W'(l2_read), '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
